ram_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single-port 8-bit RAM between the multicycle processor (port 0) and a debug/program-loader master (port 1). It sits between both masters and the memory block's `ram_readWriteN` / `ram_address` / `ram_data_in` / `ram_data_out` pins. It serialises their accesses with a req/ack handshake so that a program can be loaded or inspected while the processor runs. Memory-mapped I/O addresses pass through unchanged; the arbiter does not decode them.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/ram_arbiter_if.sv | 29 ++
 rtl/rr_pick2.sv | 14 +
 rtl/ram_arbiter.sv | 109 ++++++++++
 tb/tb_ram_arbiter.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the RAM arbiter: FSM states, port identifiers and
// RAM read/write levels.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_LDR  = 1'b1;
  localparam logic RAM_READ  = 1'b1;
  localparam logic RAM_WRITE = 1'b0;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bundle of the RAM arbiter: both ports' req/ack handshakes
// plus the shared read data and busy flag.
interface ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic              rnw0;
  logic              rnw1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (
    output req0, req1, rnw0, rnw1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata, busy
  );

  modport slave (
    input  req0, req1, rnw0, rnw1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata, busy
  );
endinterface

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin selector: on a tie the port that was not
// granted most recently wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic winner
);

  assign valid  = req0 | req1;
  assign winner = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the processor
// (port 0) and the program loader (port 1); three cycles per access.
module ram_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetN,
  ram_arbiter_if.slave      bus,
  output logic              ram_readWriteN,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  arb_state_e        state_r;
  logic              last_r;
  logic              sel_r;
  logic              ack0_r;
  logic              ack1_r;
  logic              busy_r;
  logic              ram_rwn_r;
  logic [ADDR_W-1:0] ram_addr_r;
  logic [DATA_W-1:0] ram_din_r;
  logic [DATA_W-1:0] rdata_r;
  logic              pick_valid_s;
  logic              pick_winner_s;

  rr_pick2 u_pick (
    .req0   (bus.req0),
    .req1   (bus.req1),
    .last   (last_r),
    .valid  (pick_valid_s),
    .winner (pick_winner_s)
  );

  // Arbitration FSM; the RAM drive registers double as the request capture.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r    <= IDLE;
      last_r     <= PORT_LDR;
      sel_r      <= PORT_CPU;
      ack0_r     <= 1'b0;
      ack1_r     <= 1'b0;
      busy_r     <= 1'b0;
      ram_rwn_r  <= RAM_READ;
      ram_addr_r <= {ADDR_W{1'b0}};
      ram_din_r  <= {DATA_W{1'b0}};
      rdata_r    <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            state_r <= ACCESS;
            sel_r   <= pick_winner_s;
            last_r  <= pick_winner_s;
            busy_r  <= 1'b1;
            if (pick_winner_s == PORT_LDR) begin
              ram_rwn_r  <= bus.rnw1;
              ram_addr_r <= bus.addr1;
              ram_din_r  <= bus.wdata1;
            end else begin
              ram_rwn_r  <= bus.rnw0;
              ram_addr_r <= bus.addr0;
              ram_din_r  <= bus.wdata0;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          // The write commits on this edge, so the bus drops back to read.
          state_r   <= DONE;
          ram_rwn_r <= RAM_READ;
          rdata_r   <= ram_data_out;
          if (sel_r == PORT_LDR) begin
            ack1_r <= 1'b1;
          end else begin
            ack0_r <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          ack0_r  <= 1'b0;
          ack1_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          ack0_r    <= 1'b0;
          ack1_r    <= 1'b0;
          busy_r    <= 1'b0;
          ram_rwn_r <= RAM_READ;
        end
      endcase
    end
  end

  assign bus.ack0       = ack0_r;
  assign bus.ack1       = ack1_r;
  assign bus.rdata      = rdata_r;
  assign bus.busy       = busy_r;
  assign ram_readWriteN = ram_rwn_r;
  assign ram_address    = ram_addr_r;
  assign ram_data_in    = ram_din_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural RAM
// (combinational read, write on the rising edge while readWriteN is low).
module tb_ram_arbiter;

  logic       clk;
  logic       resetN;
  logic       ram_readWriteN;
  logic [7:0] ram_address;
  logic [7:0] ram_data_in;
  logic [7:0] ram_data_out;
  logic [7:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;
  int wlow     = 0;

  ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk            (clk),
    .resetN         (resetN),
    .bus            (bus),
    .ram_readWriteN (ram_readWriteN),
    .ram_address    (ram_address),
    .ram_data_in    (ram_data_in),
    .ram_data_out   (ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_readWriteN == 1'b0) mem[ram_address] <= ram_data_in;
  end
  assign ram_data_out = mem[ram_address];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on port p, started while the arbiter is idle.
  task automatic txn(input logic p, input logic rnw, input logic [7:0] a,
                     input logic [7:0] wd, input string tag,
                     input logic chk_rd, input logic [7:0] exp_rd);
    int n;
    logic ack_p;
    logic ack_o;
    wlow = 0;
    if (p) begin
      bus.rnw1 = rnw; bus.addr1 = a; bus.wdata1 = wd; bus.req1 = 1'b1;
    end else begin
      bus.rnw0 = rnw; bus.addr0 = a; bus.wdata0 = wd; bus.req0 = 1'b1;
    end
    n = 0;
    do begin
      cyc();
      n++;
      if (!ram_readWriteN) wlow++;
      ack_p = p ? bus.ack1 : bus.ack0;
      ack_o = p ? bus.ack0 : bus.ack1;
    end while (!ack_p && n < 8);
    chk({tag, "_latency"}, n, 2);
    chk({tag, "_other_ack"}, {31'd0, ack_o}, 32'd0);
    if (chk_rd) chk({tag, "_rdata"}, {24'd0, bus.rdata}, {24'd0, exp_rd});
    if (p) bus.req1 = 1'b0;
    else   bus.req0 = 1'b0;
    cyc();
    if (!ram_readWriteN) wlow++;
    chk({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int acks;
    int ack_cyc [4];
    int ack_port [4];
    int both;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    resetN = 1'b0;
    bus.req0 = 1'b1; bus.rnw0 = 1'b1; bus.addr0 = 8'h00; bus.wdata0 = 8'h00;
    bus.req1 = 1'b0; bus.rnw1 = 1'b1; bus.addr1 = 8'h00; bus.wdata1 = 8'h00;

    // Reset state with req0 asserted
    cyc(); cyc();
    chk("rst_rwn",   {31'd0, ram_readWriteN}, 32'd1);
    chk("rst_ack0",  {31'd0, bus.ack0}, 32'd0);
    chk("rst_ack1",  {31'd0, bus.ack1}, 32'd0);
    chk("rst_busy",  {31'd0, bus.busy}, 32'd0);
    chk("rst_addr",  {24'd0, ram_address}, 32'd0);
    chk("rst_din",   {24'd0, ram_data_in}, 32'd0);
    chk("rst_rdata", {24'd0, bus.rdata}, 32'd0);
    resetN = 1'b1;
    cyc();
    chk("rel_busy_access", {31'd0, bus.busy}, 32'd1);
    chk("rel_ack0_early",  {31'd0, bus.ack0}, 32'd0);
    cyc();
    chk("rel_ack0", {31'd0, bus.ack0}, 32'd1);
    bus.req0 = 1'b0;
    cyc();
    chk("rel_ack0_pulse", {31'd0, bus.ack0}, 32'd0);
    chk("rel_busy_idle",  {31'd0, bus.busy}, 32'd0);

    // Single write then read on the loader port
    txn(1'b1, 1'b0, 8'h10, 8'h5A, "wr10", 1'b0, 8'h00);
    chk("wr10_rwn_low_cycles", wlow, 1);
    txn(1'b1, 1'b1, 8'h10, 8'h00, "rd10", 1'b1, 8'h5A);
    chk("rd10_rwn_low_cycles", wlow, 0);

    // Abandoned write: req0 dropped during ACCESS
    bus.rnw0 = 1'b0; bus.addr0 = 8'h20; bus.wdata0 = 8'h33; bus.req0 = 1'b1;
    cyc();
    bus.req0 = 1'b0;
    chk("abn_rwn_access",  {31'd0, ram_readWriteN}, 32'd0);
    chk("abn_addr_access", {24'd0, ram_address}, 32'h20);
    cyc();
    chk("abn_ack0", {31'd0, bus.ack0}, 32'd1);
    cyc();
    chk("abn_ack0_pulse", {31'd0, bus.ack0}, 32'd0);
    txn(1'b0, 1'b1, 8'h20, 8'h00, "rd20", 1'b1, 8'h33);

    // Field change after capture
    bus.rnw1 = 1'b1; bus.addr1 = 8'h05; bus.req1 = 1'b1;
    cyc();
    chk("fld_addr_access", {24'd0, ram_address}, 32'h05);
    bus.addr1 = 8'h06;
    #2;
    chk("fld_addr_after_change", {24'd0, ram_address}, 32'h05);
    cyc();
    chk("fld_ack1", {31'd0, bus.ack1}, 32'd1);
    chk("fld_addr_done", {24'd0, ram_address}, 32'h05);
    bus.req1 = 1'b0;
    cyc();

    // Reset asserted during ACCESS of a write
    txn(1'b1, 1'b0, 8'h30, 8'h77, "wr30", 1'b0, 8'h00);
    bus.rnw0 = 1'b0; bus.addr0 = 8'h30; bus.wdata0 = 8'hC3; bus.req0 = 1'b1;
    cyc();
    chk("mid_rwn_access", {31'd0, ram_readWriteN}, 32'd0);
    #1 resetN = 1'b0;
    #1;
    chk("mid_rwn_async",  {31'd0, ram_readWriteN}, 32'd1);
    chk("mid_busy_async", {31'd0, bus.busy}, 32'd0);
    chk("mid_addr_async", {24'd0, ram_address}, 32'd0);
    bus.req0 = 1'b0;
    cyc();
    chk("mid_no_ack0", {31'd0, bus.ack0}, 32'd0);
    resetN = 1'b1;
    cyc();
    txn(1'b1, 1'b1, 8'h30, 8'h00, "rd30", 1'b1, 8'h77);

    // Continuous contention from reset
    resetN = 1'b0;
    bus.rnw0 = 1'b1; bus.addr0 = 8'h10; bus.req0 = 1'b1;
    bus.rnw1 = 1'b1; bus.addr1 = 8'h20; bus.req1 = 1'b1;
    cyc();
    resetN = 1'b1;
    acks = 0;
    both = 0;
    for (int c = 1; c <= 40 && acks < 4; c++) begin
      cyc();
      if (bus.ack0 && bus.ack1) both++;
      if (bus.ack0 || bus.ack1) begin
        ack_cyc[acks]  = c;
        ack_port[acks] = bus.ack1 ? 1 : 0;
        chk($sformatf("cnt_rdata%0d", acks), {24'd0, bus.rdata},
            bus.ack1 ? 32'h33 : 32'h5A);
        acks++;
      end
    end
    chk("cnt_ack_count", acks, 4);
    chk("cnt_simultaneous", both, 0);
    chk("cnt_first_cycle", ack_cyc[0], 2);
    for (int i = 0; i < 4; i++) begin
      if (i < acks) chk($sformatf("cnt_order%0d", i), ack_port[i], i % 2);
      if (i > 0 && i < acks)
        chk($sformatf("cnt_spacing%0d", i), ack_cyc[i] - ack_cyc[i-1], 3);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    cyc(); cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
